// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: full-duplex SPI slave with TX/RX symbol FIFOs.
//
// Supports all four SPI modes, MSB- or LSB-first bit order and symbols of
// 1..DATA_W bits. Mode, bit order and symbol size are captured when chip
// select asserts and hold for the whole transfer. The firmware side streams
// symbols through valid/ready handshakes on two small FIFOs.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk, scs, sin        SPI clock, chip select (active high), MOSI
//   sout                  MISO; holds its last value while idle
//   mode, bit_order,
//   sym_size              transfer configuration, captured at chip-select rise
//   tx_data/valid/ready   TX FIFO write port (right-aligned symbols)
//   rx_data/valid/ready   RX FIFO read port (right-aligned, upper bits zero)
//   tx_level, rx_level    FIFO occupancies
//   start, stop           one-cycle pulses on transfer begin / end
//   busy                  high while a transfer is active
//   tx_underrun           one-cycle pulse: a symbol load found the TX FIFO empty
//   rx_overrun            one-cycle pulse: a received symbol was dropped (RX full)
//
// Build option: define SPI_SLAVE_FIFO_SYNC_EN to put 2-flop synchronisers on
// sclk/scs/sin (adds exactly 2 clk to every pin-derived latency). Without it
// the pins pass through a single register and must already be clk-synchronous.

module spi_slave_fifo_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  always_comb begin
    // A pop on an empty FIFO is ignored, so empty+push+pop just gives level 1.
    // A push on a full FIFO is accepted only if a pop frees a slot this cycle.
    pop_ok   = pop & (level_q != '0);
    push_ok  = push & ((level_q != (AW+1)'(DEPTH)) | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two: wraps naturally
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
endmodule

module spi_slave_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        sout,
  input  logic                        sin,
  input  logic                        sclk,
  input  logic                        scs,
  input  logic [1:0]                  mode,
  input  logic                        bit_order,
  input  logic [5:0]                  sym_size,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        start,
  output logic                        stop,
  output logic                        busy,
  output logic                        tx_underrun,
  output logic                        rx_overrun
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  // ---------------- pin capture ----------------
  logic [2:0] pins_d, pins_q;  // {sclk, scs, sin}
`ifdef SPI_SLAVE_FIFO_SYNC_EN
  logic [2:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {sclk, scs, sin};
      sync_q <= meta_q;
    end
  end
  always_comb pins_d = sync_q;
`else
  always_comb pins_d = {sclk, scs, sin};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pins_q <= '0;
    else        pins_q <= pins_d;
  end

  logic sclk_s, scs_s, sin_s;
  assign sclk_s = pins_q[2];
  assign scs_s  = pins_q[1];
  assign sin_s  = pins_q[0];

  // ---------------- FIFOs ----------------
  logic              tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_pop;
  logic [DATA_W-1:0] tx_head;
  logic              rx_pend_q, rx_pend_d;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;

  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_ready & ~rx_empty;

  spi_slave_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_valid & ~tx_full), .push_data(tx_data), .pop(tx_pop),
    .head(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  spi_slave_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_pend_q), .push_data(rx_word_q), .pop(rx_pop),
    .head(rx_data), .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- transfer engine ----------------
  state_t            state_q, state_d;
  logic              scs_prev_q, scs_prev_d, sclk_prev_q, sclk_prev_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [5:0]        size_q, size_d;
  logic              first_q, first_d;       // CPHA=0: drive bit 0 without waiting for an edge
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [5:0]        tx_idx_q, tx_idx_d;     // index of the bit the next shift edge drives
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_shift;
  logic [5:0]        rx_cnt_q, rx_cnt_d;
  logic              sout_q, sout_d, start_q, start_d, stop_q, stop_d;
  logic              underrun_q, underrun_d, overrun_q, overrun_d;
  logic              tx_load, rise, fall, sample_edge, shift_edge;
  logic [5:0]        eff_size;
  logic [DATA_W-1:0] load_word;

  function automatic logic pick_bit(input logic [DATA_W-1:0] sym, input logic [5:0] idx,
                                    input logic [5:0] size, input logic lsb);
    logic [5:0]        pos;
    logic [DATA_W-1:0] sh;
    pos = lsb ? idx : (size - 6'd1 - idx);
    sh  = sym >> pos;
    return sh[0];
  endfunction

  assign eff_size  = (sym_size == 6'd0 || sym_size > 6'(DATA_W)) ? 6'(DATA_W) : sym_size;
  assign load_word = tx_empty ? '0 : tx_head;
  assign tx_pop    = tx_load & ~tx_empty;

  always_comb begin
    state_d     = state_q;
    scs_prev_d  = scs_s;
    sclk_prev_d = sclk_s;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    size_d      = size_q;
    first_d     = first_q;
    tx_sh_d     = tx_sh_q;
    tx_idx_d    = tx_idx_q;
    rx_sh_d     = rx_sh_q;
    rx_cnt_d    = rx_cnt_q;
    rx_pend_d   = 1'b0;
    rx_word_d   = rx_word_q;
    rx_shift    = rx_sh_q;
    sout_d      = sout_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    tx_load     = 1'b0;
    rise        = sclk_s & ~sclk_prev_q;
    fall        = ~sclk_s & sclk_prev_q;
    sample_edge = (cpol_q == cpha_q) ? rise : fall;
    shift_edge  = (cpol_q == cpha_q) ? fall : rise;

    case (state_q)
      IDLE: begin
        if (scs_s & ~scs_prev_q) begin
          state_d     = ACTIVE;
          start_d     = 1'b1;
          cpol_d      = mode[1];
          cpha_d      = mode[0];
          lsb_d       = bit_order;
          size_d      = eff_size;
          sclk_prev_d = mode[1];  // any non-idle sclk level now reads as an edge
          first_d     = ~mode[0];
          tx_load     = 1'b1;
          tx_sh_d     = load_word;
          tx_idx_d    = '0;
          rx_sh_d     = '0;
          rx_cnt_d    = '0;
        end
      end
      ACTIVE: begin
        if (~scs_s & scs_prev_q) begin
          state_d  = IDLE;
          stop_d   = 1'b1;
          first_d  = 1'b0;
          tx_idx_d = '0;
          rx_sh_d  = '0;
          rx_cnt_d = '0;
        end else if (first_q) begin
          sout_d   = pick_bit(tx_sh_q, 6'd0, size_q, lsb_q);
          tx_idx_d = 6'd1;
          first_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift = lsb_q ? (rx_sh_q | (DATA_W'(sin_s) << rx_cnt_q))
                             : ((rx_sh_q << 1) | DATA_W'(sin_s));
            if (rx_cnt_q == size_q - 6'd1) begin
              rx_pend_d = 1'b1;
              rx_word_d = rx_shift;
              rx_sh_d   = '0;
              rx_cnt_d  = '0;
            end else begin
              rx_sh_d  = rx_shift;
              rx_cnt_d = rx_cnt_q + 6'd1;
            end
          end
          if (shift_edge) begin
            // A shift edge after the last bit of a symbol starts the next one.
            if (tx_idx_q == size_q) begin
              tx_load  = 1'b1;
              tx_sh_d  = load_word;
              sout_d   = pick_bit(load_word, 6'd0, size_q, lsb_q);
              tx_idx_d = 6'd1;
            end else begin
              sout_d   = pick_bit(tx_sh_q, tx_idx_q, size_q, lsb_q);
              tx_idx_d = tx_idx_q + 6'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    underrun_d = tx_load & tx_empty;
    overrun_d  = rx_pend_q & rx_full & ~rx_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scs_prev_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      size_q      <= '0;
      first_q     <= 1'b0;
      tx_sh_q     <= '0;
      tx_idx_q    <= '0;
      rx_sh_q     <= '0;
      rx_cnt_q    <= '0;
      rx_pend_q   <= 1'b0;
      rx_word_q   <= '0;
      sout_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scs_prev_q  <= scs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      size_q      <= size_d;
      first_q     <= first_d;
      tx_sh_q     <= tx_sh_d;
      tx_idx_q    <= tx_idx_d;
      rx_sh_q     <= rx_sh_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_pend_q   <= rx_pend_d;
      rx_word_q   <= rx_word_d;
      sout_q      <= sout_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sout        = sout_q;
  assign start       = start_q;
  assign stop        = stop_q;
  assign busy        = (state_q == ACTIVE);
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
`timescale 1ns/1ps
module tb_spi_slave_fifo;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = 6;   // sclk half period in clk cycles

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sout;
  logic              sin = 1'b0;
  logic              sclk = 1'b0;
  logic              scs = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              bit_order = 1'b0;
  logic [5:0]        sym_size = 6'd0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic [2:0]        tx_level, rx_level;
  logic              start, stop, busy, tx_underrun, rx_overrun;

  spi_slave_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sout(sout), .sin(sin), .sclk(sclk), .scs(scs),
    .mode(mode), .bit_order(bit_order), .sym_size(sym_size),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .start(start), .stop(stop),
    .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0, stop_cnt = 0, und_cnt = 0, ovr_cnt = 0;

  always @(posedge clk) begin
    if (start)       start_cnt <= start_cnt + 1;
    if (stop)        stop_cnt  <= stop_cnt + 1;
    if (tx_underrun) und_cnt   <= und_cnt + 1;
    if (rx_overrun)  ovr_cnt   <= ovr_cnt + 1;
  end

  // Reference state: symbols the firmware has queued / should read back.
  logic [31:0] tx_model[$];
  logic [31:0] rx_model[$];
  logic        mosi[0:255];
  logic        miso[0:255];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [31:0] d);
    @(negedge clk);
    check("tx_ready", tx_ready, tx_model.size() < FIFO_DEPTH);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (tx_model.size() < FIFO_DEPTH) tx_model.push_back(d);
    check("tx_level", tx_level, tx_model.size());
  endtask

  // Master side of one transfer of nbits clocks; records what it saw on sout.
  task automatic spi_xfer(input logic [1:0] m, input logic lsb, input logic [5:0] sz, input int nbits);
    @(negedge clk);
    mode = m; bit_order = lsb; sym_size = sz; sclk = m[1];
    repeat (4) @(negedge clk);
    scs = 1'b1;
    if (!m[0]) sin = mosi[0];
    repeat (HALF + 4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (m[0]) begin
        sclk = ~sclk; sin = mosi[i];
        repeat (HALF) @(negedge clk);
        miso[i] = sout; sclk = ~sclk;
        repeat (HALF) @(negedge clk);
      end else begin
        miso[i] = sout; sclk = ~sclk;
        repeat (HALF) @(negedge clk);
        sclk = ~sclk;
        if (i + 1 < nbits) sin = mosi[i + 1];
        repeat (HALF) @(negedge clk);
      end
    end
    scs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  function automatic logic [31:0] gather(input int base, input int size, input logic lsb, input logic from_miso);
    logic [31:0] w;
    logic        b;
    int          pos;
    w = '0;
    for (int j = 0; j < size; j++) begin
      b = from_miso ? miso[base + j] : mosi[base + j];
      pos = lsb ? j : size - 1 - j;
      w[pos] = b;
    end
    return w;
  endfunction

  // One transfer plus its reference: each symbol on the wire is the next queued
  // TX word (or zero when none is left); a symbol starts at transfer start and
  // whenever a shift edge falls after the last bit of the previous symbol.
  task automatic run(input string tag, input logic [1:0] m, input logic lsb, input logic [5:0] sz, input int nbits);
    int          size, loads, nsym, exp_und, exp_ovr;
    int          s0, p0, u0, o0;
    logic [31:0] sym[$];
    logic [63:0] mask;
    logic [31:0] w;
    size = (sz == 0 || sz > 32) ? 32 : int'(sz);
    s0 = start_cnt; p0 = stop_cnt; u0 = und_cnt; o0 = ovr_cnt;
    spi_xfer(m, lsb, sz, nbits);
    mask  = (64'd1 << size) - 64'd1;
    nsym  = nbits / size;
    loads = 1 + (m[0] ? (nbits - 1) / size : nbits / size);
    exp_und = 0; exp_ovr = 0;
    for (int k = 0; k < loads; k++) begin
      if (tx_model.size() > 0) sym.push_back(tx_model.pop_front());
      else begin sym.push_back('0); exp_und++; end
    end
    for (int s = 0; s < nsym; s++) begin
      check({tag, " miso word"}, gather(s * size, size, lsb, 1'b1), sym[s] & mask[31:0]);
      w = gather(s * size, size, lsb, 1'b0);
      if (rx_model.size() < FIFO_DEPTH) rx_model.push_back(w);
      else exp_ovr++;
    end
    $display("%s: mode=%0d lsb=%0d size=%0d bits=%0d symbols=%0d", tag, m, lsb, size, nbits, nsym);
    check({tag, " start pulses"}, start_cnt - s0, 1);
    check({tag, " stop pulses"}, stop_cnt - p0, 1);
    check({tag, " underruns"}, und_cnt - u0, exp_und);
    check({tag, " overruns"}, ovr_cnt - o0, exp_ovr);
    check({tag, " rx_level"}, rx_level, rx_model.size());
    check({tag, " tx_level"}, tx_level, tx_model.size());
  endtask

  task automatic drain_rx(input string tag);
    while (rx_model.size() > 0) begin
      @(negedge clk);
      check({tag, " rx_valid"}, rx_valid, 1);
      check({tag, " rx_data"}, rx_data, rx_model.pop_front());
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    @(negedge clk);
    check({tag, " rx empty"}, rx_valid, 0);
  endtask

  task automatic rand_mosi(input int n);
    for (int i = 0; i < n; i++) mosi[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [7:0]  b8;
    logic [1:0]  rm;
    logic [5:0]  rs;
    int          es, nsym, ntx;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst tx_ready", tx_ready, 1);
    check("rst rx_valid", rx_valid, 0);
    check("rst busy", busy, 0);
    check("rst sout", sout, 0);
    check("rst levels", {tx_level, rx_level}, 0);
    check("rst rx_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- mode 0, MSB, 8 bit: A5 out, 3C in ----
    push_tx(32'h0000_00A5);
    b8 = 8'h3C;
    for (int i = 0; i < 8; i++) mosi[i] = b8[7 - i];
    run("mode0 A5/3C", 2'd0, 1'b0, 6'd8, 8);
    drain_rx("mode0 A5/3C");

    // ---- mode 3, LSB, 12 bit, 4 back-to-back symbols ----
    for (int i = 0; i < 4; i++) push_tx($urandom);
    rand_mosi(48);
    run("mode3 lsb12 x4", 2'd3, 1'b1, 6'd12, 48);
    drain_rx("mode3 lsb12 x4");

    // ---- RX overrun on 5th symbol ----
    for (int i = 0; i < 4; i++) push_tx($urandom);
    rand_mosi(40);
    run("overrun", 2'($urandom_range(0, 3)), 1'b0, 6'd8, 40);
    drain_rx("overrun");

    // ---- TX underrun, mode 1 ----
    rand_mosi(8);
    run("underrun", 2'd1, 1'b0, 6'd8, 8);
    drain_rx("underrun");

    // ---- abort after 5 of 8 bits, then a clean transfer ----
    push_tx($urandom);
    rand_mosi(5);
    run("abort", 2'd0, 1'b0, 6'd8, 5);
    rand_mosi(8);
    run("after abort", 2'd0, 1'b0, 6'd8, 8);
    drain_rx("after abort");

    // ---- randomized transfers (sizes include 0 and >DATA_W) ----
    for (int t = 0; t < 6; t++) begin
      rm   = 2'($urandom_range(0, 3));
      rs   = 6'($urandom_range(0, 40));
      es   = (rs == 0 || rs > 32) ? 32 : int'(rs);
      nsym = $urandom_range(1, 3);
      ntx  = $urandom_range(0, nsym);
      for (int i = 0; i < ntx; i++) push_tx($urandom);
      rand_mosi(nsym * es);
      run("random", rm, 1'($urandom_range(0, 1)), rs, nsym * es);
      drain_rx("random");
      tx_model.delete();
      // The trailing CPHA=0 load may leave nothing; flush any remaining TX words.
      while (tx_level != 0) begin
        @(negedge clk); scs = 1'b1;
        repeat (4) @(negedge clk); scs = 1'b0;
        repeat (4) @(negedge clk);
      end
    end

    // ---- reset mid-transfer, mode 2, 32 bit ----
    push_tx($urandom);
    push_tx($urandom);
    @(negedge clk);
    mode = 2'd2; bit_order = 1'b0; sym_size = 6'd32; sclk = 1'b1;
    repeat (4) @(negedge clk);
    scs = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      sclk = ~sclk; sin = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
    end
    check("midxfer busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst levels", {tx_level, rx_level}, 0);
    check("async rst tx_ready", tx_ready, 1);
    check("async rst rx_valid", rx_valid, 0);
    check("async rst sout", sout, 0);
    check("async rst pulses", {start, stop, tx_underrun, rx_overrun}, 0);
    $display("reset mid-transfer: mode=2 size=32");
    scs = 1'b0; sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post rst busy", busy, 0);
    tx_model.delete();
    rx_model.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
